// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline register carrying a data payload and a control bundle.
// SKID=1 adds a second entry so that in_ready comes from registered state only.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [1:0]        occupancy_q,  occupancy_d;

    logic accept;
    logic retire;

    always_comb begin
        if (SKID != 0) begin
            in_ready = !skid_valid_q && !flush;
        end else begin
            in_ready = (!main_valid_q || out_ready) && !flush;
        end
    end

    assign accept = in_valid && in_ready;
    assign retire = main_valid_q && out_ready;

    // With SKID=0 the skid entry never fills: in_ready is low whenever main is held.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_ctrl_d  = '0;
        end else if (!main_valid_q || retire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end

        occupancy_d = 2'(main_valid_d) + 2'(skid_valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            occupancy_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: instance 0 has SKID=1, instance 1 has SKID=0.
// Directed expectations and model expectations are both compared by one negedge monitor.
module tb_pipe_stage_skid;

    localparam int F_RDY  = 0;
    localparam int F_VLD  = 1;
    localparam int F_DATA = 2;
    localparam int F_CTRL = 3;
    localparam int F_OCC  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic [7:0]  in_ctrl   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic [7:0]  out_ctrl  [2];
    logic [1:0]  occ       [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_stage_skid #(
            .DATA_W(32),
            .CTRL_W(8),
            .SKID  ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .in_ctrl  (in_ctrl[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .out_ctrl (out_ctrl[g]),
            .occupancy(occ[g])
        );
    end

    typedef struct {
        int          inst;
        int          field;
        logic [39:0] val;
        string       name;
    } dexp_t;

    dexp_t       dq [$];
    logic [39:0] sb [2][$];
    logic [31:0] hold [2];
    bit          live [2];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(string nm, int i, logic [39:0] act, logic [39:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [inst %0d]: got 0x%0h, expected 0x%0h", nm, i, act, exp);
    endtask

    function automatic logic [39:0] field_val(int i, int f);
        case (f)
            F_RDY:   return {39'b0, in_ready[i]};
            F_VLD:   return {39'b0, out_valid[i]};
            F_DATA:  return {8'b0, out_data[i]};
            F_CTRL:  return {32'b0, out_ctrl[i]};
            F_OCC:   return {38'b0, occ[i]};
            default: return '0;
        endcase
    endfunction

    // Monitor: drains directed expectations, then checks every output against the
    // reference queue and advances the queue for the coming rising edge.
    always @(negedge clk) begin
        dexp_t       de;
        int unsigned n;
        logic        exp_rdy;
        logic [39:0] hd;
        logic [39:0] exp_d;
        logic [39:0] exp_c;

        while (dq.size() != 0) begin
            de = dq.pop_front();
            check(de.name, de.inst, field_val(de.inst, de.field), de.val);
        end

        for (int i = 0; i < 2; i++) begin
            n = sb[i].size();
            exp_rdy = !flush[i] && ((i == 0) ? (n < 2) : (n == 0 || out_ready[i]));
            if (n != 0) begin
                hd    = sb[i][0];
                exp_d = {8'b0, hd[39:8]};
                exp_c = {32'b0, hd[7:0]};
            end else begin
                exp_d = {8'b0, hold[i]};
                exp_c = '0;
            end
            if (live[i]) begin
                check("m_in_ready",  i, {39'b0, in_ready[i]},  {39'b0, exp_rdy});
                check("m_out_valid", i, {39'b0, out_valid[i]}, {39'b0, (n != 0)});
                check("m_occupancy", i, {38'b0, occ[i]},       40'(n));
                check("m_out_data",  i, {8'b0, out_data[i]},   exp_d);
                check("m_out_ctrl",  i, {32'b0, out_ctrl[i]},  exp_c);
            end
            if (rst) begin
                sb[i].delete();
                hold[i] = '0;
                live[i] = 1'b1;
            end else if (live[i]) begin
                if (n != 0 && out_ready[i]) begin
                    hd = sb[i].pop_front();
                    check("retired", i, {out_data[i], out_ctrl[i]}, hd);
                end
                if (flush[i]) begin
                    sb[i].delete();
                    hold[i] = '0;
                end else if (in_valid[i] && exp_rdy) begin
                    sb[i].push_back({in_data[i], in_ctrl[i]});
                end
                if (sb[i].size() != 0) begin
                    hd = sb[i][0];
                    hold[i] = hd[39:8];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(logic v, logic [31:0] d, logic [7:0] c, logic ordy, logic fl);
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = v;
            in_data[i]   = d;
            in_ctrl[i]   = c;
            out_ready[i] = ordy;
            flush[i]     = fl;
        end
    endtask

    task automatic expect_at(int i, int f, logic [39:0] v, string nm);
        dexp_t de;
        de.inst  = i;
        de.field = f;
        de.val   = v;
        de.name  = nm;
        dq.push_back(de);
    endtask

    initial begin
        int idx;
        logic r;

        rst = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;

        // 1: reset state then streaming at full rate
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h10 + k, 8'h30 + 8'(k), 1'b1, 1'b0);
            for (int i = 0; i < 2; i++) begin
                expect_at(i, F_RDY, 40'h1, "t1_in_ready");
                if (k == 0) begin
                    expect_at(i, F_VLD,  40'h0, "t1_rst_out_valid");
                    expect_at(i, F_DATA, 40'h0, "t1_rst_out_data");
                    expect_at(i, F_CTRL, 40'h0, "t1_rst_out_ctrl");
                    expect_at(i, F_OCC,  40'h0, "t1_rst_occupancy");
                end else begin
                    expect_at(i, F_VLD,  40'h1, "t1_out_valid");
                    expect_at(i, F_DATA, 40'h10 + 40'(k - 1), "t1_out_data");
                    expect_at(i, F_OCC,  40'h1, "t1_occupancy");
                end
            end
            cyc();
        end
        drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            expect_at(i, F_DATA, 40'h14, "t1_last_data");
            expect_at(i, F_OCC,  40'h1,  "t1_last_occ");
        end
        cyc();
        for (int i = 0; i < 2; i++) begin
            expect_at(i, F_VLD,  40'h0,  "t1_drained_valid");
            expect_at(i, F_DATA, 40'h14, "t1_hold_data");
        end
        cyc();

        // 2: back-pressure into the skid entry
        drive(1'b1, 32'hA1, 8'hA1, 1'b0, 1'b0);
        expect_at(0, F_RDY, 40'h1, "t2_rdy_c1");
        expect_at(0, F_OCC, 40'h0, "t2_occ_c1");
        cyc();
        drive(1'b1, 32'hA2, 8'hA2, 1'b0, 1'b0);
        expect_at(0, F_RDY,  40'h1,  "t2_rdy_c2");
        expect_at(0, F_OCC,  40'h1,  "t2_occ_c2");
        expect_at(0, F_DATA, 40'hA1, "t2_data_c2");
        cyc();
        drive(1'b1, 32'hA3, 8'hA3, 1'b0, 1'b0);
        expect_at(0, F_RDY,  40'h0,  "t2_rdy_c3");
        expect_at(0, F_OCC,  40'h2,  "t2_occ_c3");
        expect_at(0, F_DATA, 40'hA1, "t2_data_c3");
        cyc();
        expect_at(0, F_RDY,  40'h0,  "t2_rdy_c4");
        expect_at(0, F_OCC,  40'h2,  "t2_occ_c4");
        expect_at(0, F_CTRL, 40'hA1, "t2_ctrl_c4");
        cyc();
        drive(1'b1, 32'hA3, 8'hA3, 1'b1, 1'b0);
        expect_at(0, F_DATA, 40'hA1, "t2_out_a1");
        expect_at(0, F_RDY,  40'h0,  "t2_rdy_c5");
        cyc();
        expect_at(0, F_DATA, 40'hA2, "t2_out_a2");
        expect_at(0, F_OCC,  40'h1,  "t2_occ_c6");
        expect_at(0, F_RDY,  40'h1,  "t2_rdy_c6");
        cyc();
        drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        expect_at(0, F_DATA, 40'hA3, "t2_out_a3");
        expect_at(0, F_VLD,  40'h1,  "t2_valid_a3");
        cyc();
        expect_at(0, F_OCC, 40'h0, "t2_occ_end");
        cyc();

        // 3: flush while full with a pending input
        drive(1'b1, 32'hB1, 8'hB1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'hB2, 8'hB2, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'hFF, 8'hFF, 1'b0, 1'b1);
        expect_at(0, F_OCC, 40'h2, "t3_occ_full");
        for (int i = 0; i < 2; i++) expect_at(i, F_RDY, 40'h0, "t3_rdy_flush");
        cyc();
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            expect_at(i, F_VLD,  40'h0, "t3_valid");
            expect_at(i, F_CTRL, 40'h0, "t3_ctrl");
            expect_at(i, F_DATA, 40'h0, "t3_data");
            expect_at(i, F_OCC,  40'h0, "t3_occ");
            expect_at(i, F_RDY,  40'h1, "t3_rdy_after");
        end
        cyc();
        drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        cyc();
        cyc();

        // 4: control bits gated by valid
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 8'hFF, 1'b1, 1'b0);
            for (int i = 0; i < 2; i++) begin
                expect_at(i, F_CTRL, 40'h0, "t4_ctrl_idle");
                expect_at(i, F_VLD,  40'h0, "t4_valid_idle");
            end
            cyc();
        end
        drive(1'b1, 32'h5A5A, 8'h5A, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            expect_at(i, F_CTRL, 40'h5A,   "t4_ctrl");
            expect_at(i, F_VLD,  40'h1,    "t4_valid");
            expect_at(i, F_DATA, 40'h5A5A, "t4_data");
        end
        cyc();
        cyc();

        // 5: single-entry throughput with toggling out_ready
        drive(1'b1, 32'hC0, 8'hC0, 1'b1, 1'b0);
        cyc();
        idx = 1;
        for (int k = 0; k < 6; k++) begin
            r = ((k % 2) == 0);
            drive(1'b1, 32'hC0 + 32'(idx), 8'hC0 + 8'(idx), r, 1'b0);
            expect_at(1, F_RDY,  {39'b0, r}, "t5_rdy_tracks");
            expect_at(1, F_OCC,  40'h1,      "t5_occ");
            expect_at(1, F_DATA, 40'hC0 + 40'((k + 1) / 2), "t5_data");
            cyc();
            if (r) idx++;
        end
        drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        cyc();
        cyc();

        // 6: randomised traffic with 5% flush, per-instance independent
        for (int k = 0; k < 10000; k++) begin
            for (int i = 0; i < 2; i++) begin
                flush[i]     = ($urandom_range(99) < 5);
                in_valid[i]  = ($urandom_range(99) < 70);
                out_ready[i] = ($urandom_range(99) < 60);
                in_data[i]   = $urandom;
                in_ctrl[i]   = 8'($urandom);
            end
            cyc();
        end
        drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        cyc();
        cyc();
        cyc();

        // reset in the middle of a transfer
        drive(1'b1, 32'hDD, 8'hDD, 1'b1, 1'b0);
        cyc();
        rst = 1'b1;
        drive(1'b1, 32'hEE, 8'hEE, 1'b1, 1'b0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            expect_at(i, F_VLD,  40'h0, "rst_mid_valid");
            expect_at(i, F_DATA, 40'h0, "rst_mid_data");
            expect_at(i, F_OCC,  40'h0, "rst_mid_occ");
        end
        cyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, elastic pipeline-stage register. It is the successor to the fixed EX/MEM latch. It carries an opaque data payload and a control bundle between two pipeline stages using a valid/ready handshake, with back-pressure (stall) and flush (bubble insertion). An optional 2-entry skid buffer keeps the upstream ready signal registered, so that timing paths are broken in both directions.

Parameters:
DATA_W, 32, payload width in bits (ALU result, store data, register addresses, packed by the instantiating stage).
CTRL_W, 8, control-bit width (RegWrite, MemRead, MemWrite, MemToReg, ...). Forced to zero whenever the output is not valid.
SKID, 1, 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous flush; discards all held entries.
in_valid  in  1  upstream entry present.
in_ready  out  1  stage can accept an entry this cycle.
in_data  in  DATA_W  upstream payload.
in_ctrl  in  CTRL_W  upstream control bits.
out_valid  out  1  entry presented downstream.
out_ready  in  1  downstream accepts the entry this cycle.
out_data  out  DATA_W  payload of the head entry.
out_ctrl  out  CTRL_W  control bits of the head entry; 0 when out_valid=0.
occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Transfer rules: accept when in_valid&&in_ready; retire when out_valid&&out_ready.
- Reset (rst=1 at a rising edge): main_valid=0, skid_valid=0, all data/ctrl registers=0. After reset: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1.
- rst has priority over flush; flush has priority over all handshakes.
- Flush cycle: in_ready=0 combinationally. At the edge, both valids clear and data/ctrl registers clear to 0. The input offered in that cycle is dropped. Any output retired in the same cycle counts as delivered.
- Latency: an accepted entry appears on out_* in the next cycle when the stage was empty. No combinational path from in_* to out_*.
- out_ctrl = main_valid ? main_ctrl : 0. out_data holds its last value when invalid, except after reset/flush, when it is 0.
- SKID=1:
  - in_ready = !skid_valid && !flush. Depends only on registered state plus flush.
  - Main register empty, or retiring this cycle: main loads from skid if skid_valid (skid clears, and also loads the new input if one is accepted); otherwise main loads from the input.
  - Main held and not retiring, with input accepted: the input goes to skid. in_ready drops next cycle.
  - Both full and out_ready=0: hold everything; in_ready=0.
  - Both full and out_ready=1: skid→main; in_ready=1 next cycle.
- SKID=0:
  - in_ready = (!main_valid || out_ready) && !flush.
  - Simultaneous accept and retire refills main in the same edge. This gives full throughput with one entry.
- Ordering: strict FIFO. No entry is dropped (except by flush) or duplicated.
- Holding: out_data/out_ctrl stay stable while out_valid=1 && out_ready=0.
- occupancy = main_valid + skid_valid, registered.
- Simultaneous events:
  - Accept and retire at occupancy 1: occupancy stays 1, new head.
  - Accept and retire at occupancy 2: illegal, since in_ready=0.
- Reset asserted mid-transfer: the reset cycle's handshakes are ignored.

Test Plan:
1. Reset, then stream: rst 2 cycles, then in_data=0x10..0x14 on consecutive cycles with out_ready=1. Required: out_data 0x10..0x14 one cycle later each, occupancy=1, in_ready=1 throughout.
2. Back-pressure, SKID=1: send 0xA1,0xA2,0xA3 with out_ready=0. Required: 0xA1 in main, 0xA2 in skid, in_ready=0 from the 3rd cycle, 0xA3 held upstream, occupancy=2. Then raise out_ready: 0xA1,0xA2,0xA3 emerge in order with no gaps.
3. Flush when full: occupancy=2, in_valid=1 with 0xFF, flush=1 for one cycle. Required: in_ready=0 that cycle; next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; 0xFF never appears on the output.
4. Ctrl gating: in_ctrl=8'hFF with in_valid=0 for 3 cycles. Required: out_ctrl=0 and out_valid=0 every cycle. Then a valid entry with in_ctrl=8'h5A gives out_ctrl=8'h5A one cycle later.
5. SKID=0 throughput: continuous in_valid with out_ready toggling 1,0,1,0. Required: in_ready tracks out_ready while full, no entry lost, occupancy never exceeds 1.
6. Randomised scoreboard: random in_valid/out_ready/flush at 5%, both SKID values, 10k cycles. Required: output sequence equals the input sequence minus flushed entries; out_* stable while stalled.
